// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out stage with a valid/ready load side
// and a framed serial output (ser_valid / ser_last).
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
    parameter int unsigned WIDTH     = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned         CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef PISO_PARITY_EN
        ,
        ST_PAR   = 2'd2
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_last_q, ser_last_d;
    logic               busy_q, busy_d;
    logic               accept;
`ifdef PISO_PARITY_EN
    logic               par_q, par_d;
`endif

    // State, datapath and registered serial outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next-state logic; output registers are loaded from the next state so the
    // serial outputs always describe the bit currently at the head
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif

        // Ready in idle and on the final cycle of a frame for gapless back-to-back
`ifdef PISO_PARITY_EN
        load_ready = (state_q == ST_IDLE) || (state_q == ST_PAR);
`else
        load_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_SHIFT) && (cnt_q == LAST_IDX));
`endif
        accept = load_valid && load_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = load_data;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PAR;
`else
                    if (accept) begin
                        shreg_d = load_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = load_data;
                    cnt_d   = '0;
                    par_d   = ^load_data;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        ser_valid_d = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ser_out_d   = 1'b0;
        ser_last_d  = 1'b0;
        if (state_d == ST_SHIFT) begin
            ser_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
`ifndef PISO_PARITY_EN
            ser_last_d = (cnt_d == LAST_IDX);
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_d == ST_PAR) begin
            ser_out_d  = par_d;
            ser_last_d = 1'b1;
        end
`endif
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an MSB-first and an LSB-first instance share
// one stimulus stream; expectations come from a queue of pending serial bits.
module tb_piso_serializer;

    localparam int unsigned W = 3;
`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         rdy_m, out_m, val_m, last_m, busy_m;
    logic         rdy_l, out_l, val_l, last_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .ser_out    (out_m),
        .ser_valid  (val_m),
        .ser_last   (last_m),
        .busy       (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .ser_out    (out_l),
        .ser_valid  (val_l),
        .ser_last   (last_l),
        .busy       (busy_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pending serial bits per instance: [1] = data bit, [0] = last flag
    logic [1:0]   qm[$];
    logic [1:0]   ql[$];
    logic [W-1:0] words[$];
    logic [W-1:0] sipo;
    int           sipo_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare both instances against the head of their pending-bit queues
    task automatic check_outputs();
        logic [1:0]   em;
        logic [1:0]   el;
        logic [W-1:0] ew;
        em = (qm.size() != 0) ? qm[0] : 2'b00;
        el = (ql.size() != 0) ? ql[0] : 2'b00;
        check("msb_out",   32'(out_m),  32'(em[1]));
        check("msb_valid", 32'(val_m),  32'(qm.size() != 0));
        check("msb_last",  32'(last_m), 32'(em[0]));
        check("msb_busy",  32'(busy_m), 32'(qm.size() != 0));
        check("msb_ready", 32'(rdy_m),  32'(qm.size() <= 1));
        check("lsb_out",   32'(out_l),  32'(el[1]));
        check("lsb_valid", 32'(val_l),  32'(ql.size() != 0));
        check("lsb_last",  32'(last_l), 32'(el[0]));
        check("lsb_busy",  32'(busy_l), 32'(ql.size() != 0));
        check("lsb_ready", 32'(rdy_l),  32'(ql.size() <= 1));
        // Downstream shift-in register fed by the MSB-first instance
        if (val_m === 1'b1 && sipo_n < int'(W)) begin
            sipo = {sipo[W-2:0], out_m};
            sipo_n++;
            if (sipo_n == int'(W)) begin
                check("sipo_have_word", 32'(words.size() != 0), 32'd1);
                if (words.size() != 0) begin
                    ew = words.pop_front();
                    check("sipo_word", 32'(sipo), 32'(ew));
                end
            end
        end
        if (val_m === 1'b1 && last_m === 1'b1) sipo_n = 0;
    endtask

    // One clock: check current outputs, drive inputs, advance the model
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
        bit acc;
        check_outputs();
        reset      = r;
        load_valid = v;
        load_data  = d;
        acc = r && v && (qm.size() <= 1);
        if (qm.size() != 0) void'(qm.pop_front());
        if (ql.size() != 0) void'(ql.pop_front());
        if (!r) begin
            qm.delete();
            ql.delete();
            words.delete();
            sipo_n = 0;
        end else if (acc) begin
            for (int i = 0; i < int'(W); i++) begin
                qm.push_back({d[int'(W) - 1 - i], (i == int'(W) - 1) && !PAR_EN});
                ql.push_back({d[i],               (i == int'(W) - 1) && !PAR_EN});
            end
            if (PAR_EN) begin
                qm.push_back({^d, 1'b1});
                ql.push_back({^d, 1'b1});
            end
            words.push_back(d);
        end
        @(negedge clk);
    endtask

    // Hold load_valid with a word until the model says it was accepted
    task automatic send(input logic [W-1:0] d);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            done = (qm.size() <= 1);
            cycle(1'b1, 1'b1, d);
        end
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, '0);
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 3'b111;
        sipo       = '0;
        sipo_n     = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a pending word: no frame may start
        cycle(1'b0, 1'b1, 3'b111);
        cycle(1'b0, 1'b1, 3'b111);
        idle(1);

        // Single frame
        send(3'b101);
        idle(5);

        // Back-to-back frames with the second word held valid early
        send(3'b110);
        send(3'b011);
        idle(6);

        // Early valid during the first bit is ignored until the frame's end
        send(3'b100);
        send(3'b010);
        idle(6);

        // Reset at the edge ending the second bit discards the frame
        send(3'b111);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        idle(4);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), W'($urandom));
        end
        idle(6);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
